instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 flush  input  1  synchronous clear of buffer, address and count.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-006 in_op  input  4  instruction id: 0 nop, 1 addu, 2 subu, 3 jr, 4 jalr, 5 rotr, 6 clz, 7 ori, 8 lw, 9 sw, 10 beq, 11 blez, 12 bgezal, 13 lui, 14 j, 15 jal.
REQ-007 in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
REQ-008 in_imm  input  16  immediate/offset; in_target  input  26  jump index.
REQ-009 out_valid  output  1  out_instr/out_addr hold a buffered word.
REQ-010 out_ready  input  1  word consumed when out_valid && out_ready at clk edge.
REQ-011 out_instr  output  32  encoded MIPS word; out_addr  output  32  IM byte address of that word.
REQ-012 im_full  output  1  last IM slot (0x0000_6FFC) has been assigned.
REQ-013 count  output  13  words accepted since reset/flush (0..4096).

Function
REQ-014 Encoding SHALL be: addu/subu {000000,rs,rt,rd,00000,100001/100011}; jr {000000,rs,15'b0,001000}; nop 32'b0; jalr {000000,rs,00000,rd,00000,001001}; rotr {000000,00001,rt,rd,shamt,000010}; clz {011100,rs,00000,rd,00000,100000}.
REQ-015 I-type SHALL be {opcode,rs,rt,imm}: ori 001101, lw 100011, sw 101011, beq 000100; blez {000110,rs,00000,imm}; bgezal {000001,rs,10001,imm}; lui {001111,00000,rt,imm}.
REQ-016 J-type SHALL be {000010 (j) / 000011 (jal), target}.
REQ-017 Fields not used by an instruction SHALL be forced to zero regardless of input values.
REQ-018 Encoding SHALL be computed combinationally and written into a 2-entry FIFO on acceptance; out_valid rises the cycle after acceptance (latency 1), never combinationally.
REQ-019 in_ready SHALL equal (fifo occupancy < 2) && !im_full; it SHALL NOT depend on out_ready.
REQ-020 Simultaneous push and pop SHALL be allowed at occupancy 1; occupancy unchanged, order preserved.
REQ-021 Output SHALL be FIFO-ordered; out_instr/out_addr SHALL stay stable while out_valid && !out_ready.
REQ-022 Address counter SHALL start at 0x0000_3000, be attached to each accepted word, then advance by 4.
REQ-023 Accepting the word at 0x0000_6FFC SHALL set im_full next cycle; counter SHALL NOT wrap; no further acceptance until flush/reset.
REQ-024 count SHALL increment by 1 per acceptance, saturating at 4096.
REQ-025 flush SHALL empty FIFO, set address to 0x0000_3000, clear count and im_full; flush with simultaneous push/pop: flush wins, request discarded.
REQ-026 Buffered words already in FIFO when im_full sets SHALL still drain normally.

Reset
REQ-027 reset_n low SHALL asynchronously force: FIFO empty, out_valid 0, out_instr 0, out_addr 0, address counter 0x0000_3000, count 0, im_full 0; in_ready SHALL be 0 while reset_n is low and 1 from the first edge after release.
REQ-028 Reset mid-transfer SHALL discard all buffered words; no partial word emitted.

Structure
REQ-029 Shared package SHALL hold: in_op id constants, opcode/funct constants (shared with the control decoder), IM base 0x0000_3000 and last address 0x0000_6FFC.
REQ-030 One sub-module enc_fifo2 (2-entry, 64-bit payload {addr,instr}, valid/ready both sides) SHALL hold buffering; encoder logic and address/count state in instr_encoder.

Verification
REQ-031 addu rs=1 rt=2 rd=3 (shamt=7 junk) -> out_instr 0x00221821, out_addr 0x00003000, out_valid next cycle.
REQ-032 Back-to-back ori rt=8 imm=0x1234; lui rt=1 imm=0x8000; rotr rt=2 rd=3 shamt=4 -> 0x34081234@0x3000, 0x3C018000@0x3004, 0x00221902@0x3008.
REQ-033 bgezal rs=5 imm=0xFFFF, jal target=0x0000C00 with out_ready=0 -> in_ready drops after 2 accepts; release -> 0x04B1FFFF then 0x0C000C00, stable while stalled.
REQ-034 Stream 4096 nops with out_ready=1 -> last out_addr 0x00006FFC, im_full=1, count=4096, in_ready=0; flush -> next accept at 0x3000, count=1.
REQ-035 Assert flush with in_valid=1 at occupancy 2 -> FIFO empty, request dropped, out_valid=0 next cycle; reset_n pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: request ids, opcode/funct
// fields, instruction-memory address window and the FIFO payload layout.
package instr_encoder_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned CNT_W   = 13;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned TGT_W   = 26;

   typedef enum logic [OP_W-1:0] {
      OP_NOP    = 4'd0,
      OP_ADDU   = 4'd1,
      OP_SUBU   = 4'd2,
      OP_JR     = 4'd3,
      OP_JALR   = 4'd4,
      OP_ROTR   = 4'd5,
      OP_CLZ    = 4'd6,
      OP_ORI    = 4'd7,
      OP_LW     = 4'd8,
      OP_SW     = 4'd9,
      OP_BEQ    = 4'd10,
      OP_BLEZ   = 4'd11,
      OP_BGEZAL = 4'd12,
      OP_LUI    = 4'd13,
      OP_J      = 4'd14,
      OP_JAL    = 4'd15
   } op_id_e;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OPC_REGIMM   = 6'b000001;
   localparam logic [5:0] OPC_ORI      = 6'b001101;
   localparam logic [5:0] OPC_LW       = 6'b100011;
   localparam logic [5:0] OPC_SW       = 6'b101011;
   localparam logic [5:0] OPC_BEQ      = 6'b000100;
   localparam logic [5:0] OPC_BLEZ     = 6'b000110;
   localparam logic [5:0] OPC_LUI      = 6'b001111;
   localparam logic [5:0] OPC_J        = 6'b000010;
   localparam logic [5:0] OPC_JAL      = 6'b000011;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [5:0] FN_ROTR = 6'b000010;
   localparam logic [5:0] FN_CLZ  = 6'b100000;

   localparam logic [REG_W-1:0] RT_BGEZAL = 5'b10001;
   localparam logic [REG_W-1:0] RS_ROTR   = 5'b00001;

   localparam logic [ADDR_W-1:0] IM_BASE = 32'h0000_3000;
   localparam logic [ADDR_W-1:0] IM_LAST = 32'h0000_6FFC;
   localparam logic [CNT_W-1:0]  CNT_MAX = 13'd4096;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } enc_word_t;

endpackage

// File: rtl/instr_encoder_fifo2.sv
// Two-entry valid/ready FIFO for encoded words; head register drives the output
// directly so the output is always a registered value.
module enc_fifo2
   import instr_encoder_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      flush_i,
   input  logic      in_valid_i,
   output logic      in_ready_o,
   input  enc_word_t in_data_i,
   output logic      out_valid_o,
   input  logic      out_ready_i,
   output enc_word_t out_data_o
);

   enc_word_t  head_q, head_d;
   enc_word_t  tail_q, tail_d;
   logic [1:0] occ_q, occ_d;
   logic       push_c, pop_c;

   assign in_ready_o  = (occ_q != 2'd2);
   assign out_valid_o = (occ_q != 2'd0);
   assign out_data_o  = head_q;
   assign push_c      = in_valid_i && in_ready_o;
   assign pop_c       = out_valid_o && out_ready_i;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         occ_d = 2'd0;
      end else begin
         unique case (occ_q)
            2'd0: if (push_c) begin
               head_d = in_data_i;
               occ_d  = 2'd1;
            end
            2'd1: begin
               // Push with pop at one entry replaces the head in place.
               if (push_c && pop_c) begin
                  head_d = in_data_i;
               end else if (push_c) begin
                  tail_d = in_data_i;
                  occ_d  = 2'd2;
               end else if (pop_c) begin
                  occ_d = 2'd0;
               end
            end
            2'd2: if (pop_c) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end
            default: occ_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into MIPS words, tags each with its IM address
// and buffers them in a two-entry FIFO.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    in_op,
   input  logic [REG_W-1:0]   in_rs,
   input  logic [REG_W-1:0]   in_rt,
   input  logic [REG_W-1:0]   in_rd,
   input  logic [REG_W-1:0]   in_shamt,
   input  logic [IMM_W-1:0]   in_imm,
   input  logic [TGT_W-1:0]   in_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_addr,
   output logic               im_full,
   output logic [CNT_W-1:0]   count
);

   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               full_q, full_d;
   logic               rdy_q;
   logic [INSTR_W-1:0] instr_c;
   logic               fifo_in_ready;
   logic               accept_c;
   enc_word_t          fifo_in, fifo_out;

   // Unused fields are never taken from the inputs, so they encode as zero.
   always_comb begin
      instr_c = '0;
      unique case (op_id_e'(in_op))
         OP_NOP:    instr_c = '0;
         OP_ADDU:   instr_c = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_ADDU};
         OP_SUBU:   instr_c = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_SUBU};
         OP_JR:     instr_c = {OPC_SPECIAL, in_rs, 15'd0, FN_JR};
         OP_JALR:   instr_c = {OPC_SPECIAL, in_rs, 5'd0, in_rd, 5'd0, FN_JALR};
         OP_ROTR:   instr_c = {OPC_SPECIAL, RS_ROTR, in_rt, in_rd, in_shamt, FN_ROTR};
         OP_CLZ:    instr_c = {OPC_SPECIAL2, in_rs, 5'd0, in_rd, 5'd0, FN_CLZ};
         OP_ORI:    instr_c = {OPC_ORI, in_rs, in_rt, in_imm};
         OP_LW:     instr_c = {OPC_LW, in_rs, in_rt, in_imm};
         OP_SW:     instr_c = {OPC_SW, in_rs, in_rt, in_imm};
         OP_BEQ:    instr_c = {OPC_BEQ, in_rs, in_rt, in_imm};
         OP_BLEZ:   instr_c = {OPC_BLEZ, in_rs, 5'd0, in_imm};
         OP_BGEZAL: instr_c = {OPC_REGIMM, in_rs, RT_BGEZAL, in_imm};
         OP_LUI:    instr_c = {OPC_LUI, 5'd0, in_rt, in_imm};
         OP_J:      instr_c = {OPC_J, in_target};
         OP_JAL:    instr_c = {OPC_JAL, in_target};
         default:   instr_c = '0;
      endcase
   end

   assign in_ready = rdy_q && fifo_in_ready && !full_q;
   assign accept_c = in_valid && in_ready && !flush;
   assign fifo_in  = '{addr: addr_q, instr: instr_c};

   // Address stops at the last IM slot; im_full then blocks further accepts.
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      if (flush) begin
         addr_d = IM_BASE;
         cnt_d  = '0;
         full_d = 1'b0;
      end else if (accept_c) begin
         if (addr_q == IM_LAST) begin
            full_d = 1'b1;
         end else begin
            addr_d = addr_q + 32'd4;
         end
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 13'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= IM_BASE;
         cnt_q  <= '0;
         full_q <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         rdy_q  <= 1'b1;
      end
   end

   enc_fifo2 u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid && rdy_q && !full_q && !flush),
      .in_ready_o  (fifo_in_ready),
      .in_data_i   (fifo_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (fifo_out)
   );

   assign out_instr = fifo_out.instr;
   assign out_addr  = fifo_out.addr;
   assign im_full   = full_q;
   assign count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors with hand-computed words,
// checked by an independent output monitor.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, im_full;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic [31:0] out_instr, out_addr;
   logic [12:0] count;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_addr = 32'h3000;
   int          exp_count = 0;
   logic [31:0] last_addr = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .im_full(im_full), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every consumed word must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got instr 0x%0h addr 0x%0h expected none", out_instr, out_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_instr", out_instr, e.instr);
            check("out_addr", out_addr, e.addr);
            last_addr = out_addr;
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp_instr, output bit ok);
      int waited = 0;
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_imm = imm; in_target = tgt; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      ok = in_ready;
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
      end else begin
         sb.push_back('{addr: exp_addr, instr: exp_instr});
         exp_addr  = exp_addr + 32'd4;
         exp_count = (exp_count < 4096) ? exp_count + 1 : exp_count;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      sb.delete();
      exp_addr  = 32'h3000;
      exp_count = 0;
   endtask

   task automatic do_flush();
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      model_clear();
   endtask

   initial begin
      bit ok;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_imm = '0; in_target = '0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", out_addr, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_im_full", 32'(im_full), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 check("in_ready_after_edge", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      // addu with junk shamt, then latency-1 out_valid
      send(4'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'hABCD, 26'h155_5555, 32'h0022_1821, ok);
      check("latency1_out_valid", 32'(out_valid), 32'd1);
      check("count_after_first", 32'(count), 32'd1);

      send(4'd7,  5'd0,  5'd8,  5'd5,  5'd3,  16'h1234, 26'h0,        32'h3408_1234, ok);
      send(4'd13, 5'd7,  5'd1,  5'd4,  5'd2,  16'h8000, 26'h3FF_FFFF, 32'h3C01_8000, ok);
      send(4'd5,  5'd9,  5'd2,  5'd3,  5'd4,  16'hFFFF, 26'h0,        32'h0022_1902, ok);
      send(4'd2,  5'd31, 5'd0,  5'd1,  5'd5,  16'h0,    26'h0,        32'h03E0_0823, ok);
      send(4'd3,  5'd31, 5'd5,  5'd6,  5'd7,  16'hFFFF, 26'h0,        32'h03E0_0008, ok);
      send(4'd4,  5'd4,  5'd9,  5'd31, 5'd1,  16'h0,    26'h0,        32'h0080_F809, ok);
      send(4'd6,  5'd6,  5'd3,  5'd7,  5'd2,  16'h0,    26'h0,        32'h70C0_3820, ok);
      send(4'd8,  5'd29, 5'd8,  5'd1,  5'd1,  16'hFFFC, 26'h0,        32'h8FA8_FFFC, ok);
      send(4'd9,  5'd29, 5'd9,  5'd1,  5'd1,  16'h0004, 26'h0,        32'hAFA9_0004, ok);
      send(4'd10, 5'd1,  5'd2,  5'd9,  5'd9,  16'h0003, 26'h0,        32'h1022_0003, ok);
      send(4'd11, 5'd3,  5'd7,  5'd9,  5'd9,  16'h0010, 26'h0,        32'h1860_0010, ok);
      send(4'd14, 5'd3,  5'd7,  5'd9,  5'd9,  16'hFFFF, 26'h3FF_FFFF, 32'h0BFF_FFFF, ok);
      send(4'd0,  5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 32'h0000_0000, ok);
      wait_drain();
      check("count_directed", 32'(count), 32'd14);

      // Stall: two accepts fill the FIFO, head must hold steady
      out_ready = 1'b0;
      send(4'd12, 5'd5, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0,     32'h04B1_FFFF, ok);
      send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h0C00,  32'h0C00_0C00, ok);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_instr", out_instr, 32'h04B1_FFFF);
         check("stall_out_addr", out_addr, 32'h0000_3038);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();
      check("count_after_stall", 32'(count), 32'd16);

      // Fill the whole IM window with nops
      do_flush();
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4096; i++) begin
         send(4'd0, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'(i), 26'(i), 32'd0, ok);
         if (!ok) break;
      end
      wait_drain();
      check("last_addr", last_addr, 32'h0000_6FFC);
      check("full_im_full", 32'(im_full), 32'd1);
      check("full_count", 32'(count), 32'd4096);
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      check("full_count_held", 32'(count), 32'd4096);
      check("full_no_output", 32'(out_valid), 32'd0);
      do_flush();
      check("refl_im_full", 32'(im_full), 32'd0);
      check("refl_count", 32'(count), 32'd0);
      check("refl_in_ready", 32'(in_ready), 32'd1);
      send(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821, ok);
      wait_drain();
      check("refl_count_one", 32'(count), 32'd1);
      check("refl_addr", last_addr, 32'h0000_3000);

      // Flush at occupancy 2 with a concurrent request
      out_ready = 1'b0;
      send(4'd7,  5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3408_1234, ok);
      send(4'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h3C01_8000, ok);
      @(negedge clk);
      check("occ2_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 begin in_valid = 1'b1; in_op = 4'd1; flush = 1'b1; end
      @(posedge clk);
      #1 begin in_valid = 1'b0; flush = 1'b0; end
      model_clear();
      check("flushpush_out_valid", 32'(out_valid), 32'd0);
      check("flushpush_count", 32'(count), 32'd0);
      check("flushpush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 check("flushpush_out_valid_later", 32'(out_valid), 32'd0);

      // Reset mid-stream
      send(4'd7,  5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3408_1234, ok);
      send(4'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h3C01_8000, ok);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_instr", out_instr, 32'd0);
      check("midrst_out_addr", out_addr, 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_im_full", 32'(im_full), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      model_clear();
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1 check("postrst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 32'h0FFF_FFFF, ok);
      wait_drain();
      check("postrst_addr", last_addr, 32'h0000_3000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
